redmule_mx_exp_prefetch: RTL and testbench



---
 rtl/redmule_mx_exp_prefetch_if.sv | 11 +
 rtl/redmule_mx_exp_prefetch.sv | 117 +++++++++++
 tb/tb_redmule_mx_exp_prefetch.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_mx_exp_prefetch_if.sv
// Valid/ready stream bundle carrying packed exponent beats into the prefetcher.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport source (output valid, output data, input ready);
    modport sink   (input valid, input data, output ready);
endinterface

// File: rtl/redmule_mx_exp_prefetch.sv
// Exponent prefetcher: buffers packed shared-exponent beats in a small FIFO and
// serves them one entry at a time on a register-style data/valid/consume port.
module redmule_mx_exp_prefetch #(
    parameter int unsigned STREAM_W        = 32,
    parameter int unsigned EXP_W           = 8,
    parameter int unsigned BEAT_FIFO_DEPTH = 2,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        total_exp_i,
    hwpe_stream_intf_stream.sink    exp_i,
    output logic [EXP_W-1:0]        exp_data_o,
    output logic                    exp_valid_o,
    input  logic                    exp_consume_i,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int unsigned EPB    = STREAM_W / EXP_W;
    localparam int unsigned SEL_W  = (EPB > 1) ? $clog2(EPB) : 1;
    localparam int unsigned PTR_W  = $clog2(BEAT_FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(BEAT_FIFO_DEPTH + 1);

    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(EPB - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BEAT_FIFO_DEPTH - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(BEAT_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         rem_q, beats_left_q, beats_total;
    logic [SEL_W-1:0]         sel_q;
    logic [PTR_W-1:0]         head_q, tail_q;
    logic [FCNT_W-1:0]        count_q;
    logic [STREAM_W-1:0]      fifo_q [BEAT_FIFO_DEPTH];
    logic [EPB-1:0][EXP_W-1:0] head_entries;
    logic                     ready, push, pop, pop_beat, last_pop, start_job;

    // Beats needed = ceil(total/EPB); quotient plus remainder flag cannot overflow.
    assign beats_total = total_exp_i / CNT_W'(EPB)
                       + CNT_W'((total_exp_i % CNT_W'(EPB)) != '0);

    assign start_job   = (state_q == IDLE) && start_i;
    assign ready       = (state_q == RUN) && (count_q != FIFO_FULL) && (beats_left_q != '0);
    assign exp_i.ready = ready;
    assign push        = exp_i.valid && ready;

    assign head_entries = fifo_q[head_q];
    assign exp_valid_o  = (state_q == RUN) && (count_q != '0) && (rem_q != '0);
    assign exp_data_o   = exp_valid_o ? head_entries[sel_q] : '0;

    assign pop      = exp_consume_i && exp_valid_o;
    assign last_pop = pop && (rem_q == CNT_W'(1));
    // The last entry of a job retires its beat even if upper entries remain unread.
    assign pop_beat = pop && ((sel_q == SEL_LAST) || (rem_q == CNT_W'(1)));

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) state_q <= IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (total_exp_i != '0) ? RUN : DONE;
            RUN:     if (last_pop) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rem_q        <= '0;
            beats_left_q <= '0;
            sel_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else if (start_job) begin
            rem_q        <= total_exp_i;
            beats_left_q <= beats_total;
            sel_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            if (push) begin
                tail_q       <= (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
                beats_left_q <= beats_left_q - CNT_W'(1);
            end
            if (pop) begin
                rem_q <= rem_q - CNT_W'(1);
                if (pop_beat) begin
                    head_q <= (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
                    sel_q  <= '0;
                end else begin
                    sel_q  <= sel_q + SEL_W'(1);
                end
            end
            case ({push, pop_beat})
                2'b10:   count_q <= count_q + FCNT_W'(1);
                2'b01:   count_q <= count_q - FCNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[tail_q] <= exp_i.data;
    end
endmodule

// File: tb/tb_redmule_mx_exp_prefetch.sv
// Self-checking bench for redmule_mx_exp_prefetch (STREAM_W=32, EXP_W=8, depth 2)
// against a queue-based model of entries, beats and job phases.
module tb_redmule_mx_exp_prefetch;
    localparam int EPB   = 4;
    localparam int DEPTH = 2;

    logic        clk_i, rst_i, clear_i, start_i, exp_consume_i;
    logic [15:0] total_exp_i;
    logic [7:0]  exp_data_o;
    logic        exp_valid_o, busy_o, done_o;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) exp_if ();

    redmule_mx_exp_prefetch #(
        .STREAM_W(32), .EXP_W(8), .BEAT_FIFO_DEPTH(DEPTH), .CNT_W(16)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .total_exp_i   (total_exp_i),
        .exp_i         (exp_if),
        .exp_data_o    (exp_data_o),
        .exp_valid_o   (exp_valid_o),
        .exp_consume_i (exp_consume_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 idle, 1 run, 2 done.
    int          m_phase, m_total, m_need, m_acc, m_cons, done_seen;
    logic [7:0]  m_ent[$];
    logic [31:0] src[$];
    logic [7:0]  got[$];
    logic [11:0] exp_vec, obs_vec;

    task automatic model_reset();
        m_phase = 0; m_total = 0; m_need = 0; m_acc = 0; m_cons = 0;
        m_ent.delete(); got.delete(); done_seen = 0;
    endtask

    task automatic do_reset();
        rst_i = 1; clear_i = 0; start_i = 0; exp_consume_i = 0; total_exp_i = '0;
        exp_if.valid = 0; exp_if.data = '0;
        src.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
        model_reset();
    endtask

    // Samples the current cycle into obs_vec/exp_vec, drives one edge of stimulus.
    task automatic cycle(input bit st, input int tot, input bit cons);
        int          buffered;
        bit          e_ready, e_valid, push, pop;
        logic [7:0]  e_data;
        logic [31:0] beat;
        buffered = m_acc - (m_cons / EPB);
        e_ready  = (m_phase == 1) && (m_acc < m_need) && (buffered < DEPTH);
        e_valid  = (m_phase == 1) && (m_ent.size() > 0);
        e_data   = e_valid ? m_ent[0] : 8'h00;
        exp_vec  = {e_ready, e_valid, (m_phase == 1), (m_phase == 2), e_data};
        obs_vec  = {exp_if.ready, exp_valid_o, busy_o, done_o, exp_data_o};
        start_i = st; total_exp_i = 16'(tot); exp_consume_i = cons;
        exp_if.valid = (src.size() > 0);
        beat = (src.size() > 0) ? src[0] : 32'h0;
        exp_if.data = beat;
        push = exp_if.valid && e_ready;
        pop  = cons && e_valid;
        if (done_o) done_seen++;
        if (pop) got.push_back(exp_data_o);
        if (push) begin
            for (int k = 0; k < EPB; k++)
                if (m_acc * EPB + k < m_total) m_ent.push_back(beat[k*8 +: 8]);
            m_acc++;
            void'(src.pop_front());
        end
        if (pop) begin
            void'(m_ent.pop_front());
            m_cons++;
        end
        case (m_phase)
            0: if (st) begin
                m_total = tot; m_need = (tot + EPB - 1) / EPB;
                m_acc = 0; m_cons = 0; m_ent.delete();
                m_phase = (tot != 0) ? 1 : 2;
            end
            1: if (pop && m_cons == m_total) m_phase = 2;
            default: m_phase = 0;
        endcase
        @(posedge clk_i);
        #1 start_i = 0; exp_consume_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; clear_i = 0; start_i = 1; total_exp_i = 16'd5; exp_consume_i = 0;
        exp_if.valid = 1; exp_if.data = 32'h04030201;
        repeat (2) begin
            @(posedge clk_i); #1;
            if ({exp_if.ready, exp_valid_o, busy_o, done_o, exp_data_o} !== 12'h0) begin
                errors++;
                $display("FAIL reset_outputs got=%h want=000", {exp_if.ready, exp_valid_o, busy_o, done_o, exp_data_o});
            end
            checks++;
        end
        rst_i = 0; start_i = 0; exp_if.valid = 0;
        model_reset(); src.delete();
        src.push_back(32'h04030201); src.push_back(32'h08070605);
        cycle(1, 8, 0);
        if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_start got=%h want=%h", obs_vec, exp_vec); end
        checks++;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1);
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_run got=%h want=%h", obs_vec, exp_vec); end
            checks++;
        end
        clear_i = 1; exp_if.valid = 1; exp_if.data = 32'h0C0B0A09;
        repeat (2) begin
            @(posedge clk_i); #1 clear_i = 0;
            if ({exp_if.ready, exp_valid_o, busy_o, done_o, exp_data_o} !== 12'h0) begin
                errors++;
                $display("FAIL clear_outputs got=%h want=000", {exp_if.ready, exp_valid_o, busy_o, done_o, exp_data_o});
            end
            checks++;
        end
        exp_if.valid = 0;
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        src.push_back(32'h04030201); src.push_back(32'hAA0B0605); src.push_back(32'hDEADBEEF);
        cycle(1, 6, 0);
        if (obs_vec !== exp_vec) begin errors++; $display("FAIL basic_start got=%h want=%h", obs_vec, exp_vec); end
        checks++;
        n = 0;
        while (m_phase != 0 && n < 40) begin
            cycle(0, 0, 1);
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL basic_cycle got=%h want=%h", obs_vec, exp_vec); end
            checks++;
            n++;
        end
        if (n >= 40) begin errors++; $display("FAIL basic_timeout cycles=%0d limit=40", n); end
        checks++;
        for (int i = 0; i < 6; i++) begin
            if (got.size() <= i || got[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL basic_seq idx=%0d got=%h want=%h", i, (got.size() > i) ? got[i] : 8'hxx, 8'(i + 1));
            end
            checks++;
        end
        if (done_seen != 1) begin errors++; $display("FAIL basic_done pulses=%0d want=1", done_seen); end
        checks++;
        if (src.size() != 1) begin errors++; $display("FAIL basic_surplus left=%0d want=1", src.size()); end
        checks++;
        src.delete(); exp_if.valid = 0;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        src.push_back(32'h04030201); src.push_back(32'h08070605); src.push_back(32'h0C0B0A09);
        cycle(1, 12, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0);
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_fill got=%h want=%h", obs_vec, exp_vec); end
            checks++;
        end
        if (exp_if.ready !== 1'b0 || exp_data_o !== 8'h01 || src.size() != 1) begin
            errors++; $display("FAIL bp_full ready=%b data=%h left=%0d want ready=0 data=01 left=1", exp_if.ready, exp_data_o, src.size());
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1);
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_drain got=%h want=%h", obs_vec, exp_vec); end
            checks++;
        end
        if (exp_if.ready !== 1'b1) begin errors++; $display("FAIL bp_slot_free ready=%b want=1", exp_if.ready); end
        checks++;
        cycle(0, 0, 0);
        if (src.size() != 0) begin errors++; $display("FAIL bp_third_beat left=%0d want=0", src.size()); end
        checks++;
        n = 0;
        while (m_phase != 0 && n < 40) begin
            cycle(0, 0, 1);
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_cycle got=%h want=%h", obs_vec, exp_vec); end
            checks++;
            n++;
        end
        for (int i = 0; i < 12; i++) begin
            if (got.size() <= i || got[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL bp_seq idx=%0d want=%h", i, 8'(i + 1));
            end
            checks++;
        end
    endtask

    task automatic test_wraparound();
        int n;
        do_reset();
        src.push_back(32'h04030201); src.push_back(32'h08070605);
        src.push_back(32'h0C0B0A09); src.push_back(32'h100F0E0D);
        cycle(1, 16, 0);
        n = 0;
        while (m_phase != 0 && n < 300) begin
            cycle(0, 0, 1'($urandom_range(0, 1)));
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL wrap_cycle got=%h want=%h", obs_vec, exp_vec); end
            checks++;
            n++;
        end
        if (n >= 300) begin errors++; $display("FAIL wrap_timeout cycles=%0d limit=300", n); end
        checks++;
        for (int i = 0; i < 16; i++) begin
            if (got.size() <= i || got[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL wrap_seq idx=%0d want=%h", i, 8'(i + 1));
            end
            checks++;
        end
        if (done_seen != 1) begin errors++; $display("FAIL wrap_done pulses=%0d want=1", done_seen); end
        checks++;
    endtask

    task automatic test_zero_length();
        do_reset();
        src.push_back(32'h55555555);
        cycle(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1);
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL zero_cycle got=%h want=%h", obs_vec, exp_vec); end
            checks++;
        end
        if (done_seen != 1 || src.size() != 1) begin
            errors++; $display("FAIL zero_done pulses=%0d left=%0d want pulses=1 left=1", done_seen, src.size());
        end
        checks++;
        src.delete(); exp_if.valid = 0;
    endtask

    task automatic test_clear_mid_job();
        int n;
        do_reset();
        src.push_back(32'h04030201); src.push_back(32'h08070605);
        cycle(1, 8, 0);
        n = 0;
        while (got.size() < 3 && n < 20) begin
            cycle(0, 0, 1);
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL clr_run got=%h want=%h", obs_vec, exp_vec); end
            checks++;
            n++;
        end
        clear_i = 1;
        @(posedge clk_i); #1 clear_i = 0;
        src.delete(); exp_if.valid = 0;
        repeat (2) begin
            if ({exp_valid_o, busy_o, done_o, exp_data_o} !== 11'h0) begin
                errors++; $display("FAIL clr_idle got=%h want=000", {exp_valid_o, busy_o, done_o, exp_data_o});
            end
            checks++;
            @(posedge clk_i); #1;
        end
        model_reset();
        src.push_back(32'h44332211);
        cycle(1, 4, 1);
        n = 0;
        while (m_phase != 0 && n < 20) begin
            cycle(0, 0, 1);
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL clr_job2 got=%h want=%h", obs_vec, exp_vec); end
            checks++;
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            if (got.size() <= i || got[i] !== 8'(8'h11 * (i + 1))) begin
                errors++; $display("FAIL clr_seq idx=%0d want=%h", i, 8'(8'h11 * (i + 1)));
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        int          tots[4];
        int          job, n, nb;
        logic [31:0] w;
        logic [7:0]  want[$];
        do_reset();
        for (int j = 0; j < 4; j++) begin
            tots[j] = $urandom_range(1, 9);
            nb = (tots[j] + EPB - 1) / EPB;
            for (int b = 0; b < nb; b++) begin
                w = $urandom;
                src.push_back(w);
                for (int k = 0; k < EPB; k++)
                    if (b * EPB + k < tots[j]) want.push_back(w[k*8 +: 8]);
            end
        end
        job = 0; n = 0;
        while ((job < 4 || m_phase != 0) && n < 400) begin
            if (m_phase == 0 && job < 4) begin
                cycle(1, tots[job], 1'($urandom_range(0, 1)));
                job++;
            end else begin
                cycle(0, 0, 1'($urandom_range(0, 1)));
            end
            if (obs_vec !== exp_vec) begin errors++; $display("FAIL b2b_cycle got=%h want=%h", obs_vec, exp_vec); end
            checks++;
            n++;
        end
        if (n >= 400) begin errors++; $display("FAIL b2b_timeout cycles=%0d limit=400", n); end
        checks++;
        if (got.size() != want.size()) begin
            errors++; $display("FAIL b2b_count got=%0d want=%0d", got.size(), want.size());
        end
        checks++;
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            if (got[i] !== want[i]) begin errors++; $display("FAIL b2b_seq idx=%0d got=%h want=%h", i, got[i], want[i]); end
            checks++;
        end
        if (done_seen != 4) begin errors++; $display("FAIL b2b_done pulses=%0d want=4", done_seen); end
        checks++;
    endtask

    initial begin
        rst_i = 1; clear_i = 0; start_i = 0; exp_consume_i = 0; total_exp_i = '0;
        exp_if.valid = 0; exp_if.data = '0;
        model_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_wraparound();
        test_zero_length();
        test_clear_mid_job();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
